// File: rtl/tb_console_pkg.sv
// Shared constants and types for the simulation console / end-of-test device.
// Register offsets inside the 8-byte window and the STATUS register layout.
package tb_console_pkg;

    localparam logic [2:0] TXDATA_OFS = 3'h0;
    localparam logic [2:0] STATUS_OFS = 3'h4;

    localparam int STAT_FULL_BIT    = 0;
    localparam int STAT_EMPTY_BIT   = 1;
    localparam int STAT_EOTP_BIT    = 2;
    localparam int STAT_EOT_BIT     = 3;
    localparam int STAT_COUNT_LSB   = 8;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [3:0]  rsvd_lo;
        logic        eot;
        logic        eot_pending;
        logic        empty;
        logic        full;
    } console_status_t;

endpackage

// File: rtl/tb_console_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata_o whenever
// the FIFO is not empty, and pop simply advances the read pointer.
module tb_console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/tb_console_dev.sv
// Memory-mapped console and end-of-test device: decodes TXDATA/STATUS, buffers
// characters for the bench printer and raises a sticky EOT once drained.
module tb_console_dev
    import tb_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h80040200,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        eot_o,
    output logic [6:0]  eot_code_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit, is_tx, is_st, tx_wr, gnt, accept_tx, push, set_eot;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      fifo_head;
    logic            eot_pending_q;
    logic            eot_q;
    logic [6:0]      eot_code_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    console_status_t status;
    logic            unused_bits;

    assign unused_bits = ^{data_be_i[3:1], data_wdata_i[31:8]};

    always_comb begin
        hit   = data_req_i && (data_addr_i[31:3] == BASE_ADDR[31:3]);
        is_tx = (data_addr_i[2:0] == TXDATA_OFS);
        is_st = (data_addr_i[2:0] == STATUS_OFS);
        tx_wr = hit && data_we_i && is_tx;
        // A full FIFO stalls character writes, but once EOT is pending they are dropped instead.
        gnt   = hit && !(tx_wr && fifo_full && !eot_pending_q);

        accept_tx = gnt && tx_wr && data_be_i[0] && !eot_pending_q;
        push      = accept_tx && !data_wdata_i[7];
        set_eot   = accept_tx && data_wdata_i[7];

        status             = '0;
        status.full        = fifo_full;
        status.empty       = fifo_empty;
        status.eot_pending = eot_pending_q;
        status.eot         = eot_q;
        status.count       = 8'(fifo_count);

        rdata_d = '0;
        err_d   = 1'b0;
        if (data_we_i) begin
            err_d = !(is_tx && data_be_i[0]);
        end else if (is_st) begin
            rdata_d = status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            eot_pending_q <= 1'b0;
            eot_code_q    <= '0;
            eot_q         <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= gnt ? rdata_d : '0;
            err_q    <= gnt && err_d;
            if (set_eot) begin
                eot_pending_q <= 1'b1;
                eot_code_q    <= data_wdata_i[6:0];
            end
            if (eot_pending_q && fifo_empty) eot_q <= 1'b1;
        end
    end

    tb_console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (data_wdata_i[7:0]),
        .pop_i   (char_valid_o && char_ready_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign char_valid_o  = !fifo_empty;
    assign char_o        = fifo_head;
    assign eot_o         = eot_q;
    assign eot_code_o    = eot_code_q;

endmodule

// File: tb/tb_tb_console_dev.sv
// Bench for the console device: queue-based reference model checked every
// cycle, plus directed accesses with hand-computed literal expectations.
module tb_tb_console_dev;

    localparam logic [31:0] BASE  = 32'h80040200;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, err, char_valid, eot;
    logic [31:0] rdata;
    logic [7:0]  char_byte;
    logic        ready = 1'b0;
    logic [6:0]  eot_code;

    int total = 0;
    int bad   = 0;

    tb_console_dev #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_req_i    (req),
        .data_addr_i   (addr),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_wdata_i  (wdata),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_rdata_o  (rdata),
        .data_err_o    (err),
        .char_valid_o  (char_valid),
        .char_o        (char_byte),
        .char_ready_i  (ready),
        .eot_o         (eot),
        .eot_code_o    (eot_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: character queue plus EOT flags and the pending response.
    byte unsigned mq[$];
    bit           m_pend, m_eot, m_rv, m_err;
    bit [6:0]     m_code;
    bit [31:0]    m_rd;

    function automatic bit m_gnt();
        bit hit;
        hit = req && (addr[31:3] == BASE[31:3]);
        return hit && !(we && addr[2:0] == 3'h0 && mq.size() == DEPTH && !m_pend);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pend = 0; m_eot = 0; m_code = 0; m_rv = 0; m_rd = 0; m_err = 0;
        end else begin
            bit g;
            int sz;
            g  = m_gnt();
            sz = mq.size();
            m_rv = g; m_rd = 0; m_err = 0;
            if (g) begin
                if (we) m_err = !(addr[2:0] == 3'h0 && be[0]);
                else if (addr[2:0] == 3'h4)
                    m_rd = {16'h0, 8'(sz), 4'h0, m_eot, m_pend, sz == 0, sz == DEPTH};
            end
            if (m_pend && sz == 0) m_eot = 1;
            if (sz > 0 && ready) void'(mq.pop_front());
            if (g && we && addr[2:0] == 3'h0 && be[0] && !m_pend) begin
                if (wdata[7]) begin
                    m_pend = 1;
                    m_code = wdata[6:0];
                end else begin
                    mq.push_back(wdata[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {gnt, rvalid, err, char_valid, eot, eot_code, char_byte},
                '0);
            chk("reset_rdata", rdata, '0);
        end else begin
            chk("gnt", gnt, m_gnt());
            chk("rvalid", rvalid, m_rv);
            if (m_rv) begin
                chk("rdata", rdata, m_rd);
                chk("err", err, m_err);
            end
            chk("char_valid", char_valid, mq.size() > 0);
            if (mq.size() > 0) chk("char_o", char_byte, mq[0]);
            chk("eot", eot, m_eot);
            chk("eot_code", eot_code, m_code);
        end
    end

    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input int maxc, output logic granted);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        granted = 1'b0;
        for (int i = 0; i < maxc && !granted; i++) begin
            @(negedge clk);
            granted = gnt;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        $display("acc addr=%h we=%0d be=%h wdata=%h gnt=%0d rvalid=%0d rdata=%h err=%0d",
                 a, w, b, d, granted, rvalid, rdata, err);
    endtask

    task automatic wr_char(input logic [7:0] d);
        logic g;
        access(BASE, 1'b1, 4'h1, {24'h0, d}, 1, g);
        chk("wr_granted", g, 1'b1);
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        logic g;
        access(BASE + 32'h4, 1'b0, 4'hF, '0, 4, g);
        chk({name, "_gnt"}, g, 1'b1);
        chk(name, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        int   cyc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_eot", eot, 1'b0);
        rd_status("status_reset", 32'h0000_0002);

        // Two characters with the printer ready.
        ready = 1'b1;
        wr_char(8'h48);
        chk("hello_rvalid", {rvalid, err}, 2'b10);
        chk("hello_char0", char_byte, 8'h48);
        wr_char(8'h69);
        chk("hello_char1", char_byte, 8'h69);
        @(posedge clk); #1;
        chk("hello_drained", char_valid, 1'b0);

        // Fill with the printer stalled, then free one slot for the 17th write.
        ready = 1'b0;
        for (int i = 0; i < 16; i++) wr_char(8'h30 + 8'(i));
        rd_status("status_full", 32'h0000_1001);
        req = 1'b1; addr = BASE; we = 1'b1; be = 4'h1; wdata = 32'h40; ready = 1'b1;
        @(negedge clk);
        chk("stall_gnt", gnt, 1'b0);
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        chk("unstall_gnt", gnt, 1'b1);
        @(posedge clk); #1 req = 1'b0;
        rd_status("status_refull", 32'h0000_1001);
        ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 ready = 1'b0;

        // Error writes leave the FIFO alone.
        wr_char(8'h7A);
        access(BASE + 32'h4, 1'b1, 4'hF, 32'h55, 1, g);
        chk("status_wr_err", {g, rvalid, err}, 3'b111);
        access(BASE, 1'b1, 4'b0010, 32'h42, 1, g);
        chk("be_err", {g, rvalid, err}, 3'b111);
        rd_status("status_after_err", 32'h0000_0100);
        chk("err_head", char_byte, 8'h7A);

        // Misses outside the window.
        access(BASE + 32'h8, 1'b1, 4'h1, 32'h43, 1, g);
        chk("miss_hi", {g, rvalid}, 2'b00);
        access(32'h80040100, 1'b0, 4'hF, '0, 1, g);
        chk("miss_lo", {g, rvalid}, 2'b00);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;

        // Reset straight after a grant with five characters buffered.
        for (int i = 0; i < 5; i++) wr_char(8'h50 + 8'(i));
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_char_valid", char_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_status("status_after_rst", 32'h0000_0002);

        // End of test with three characters still buffered.
        wr_char(8'h61); wr_char(8'h62); wr_char(8'h63);
        wr_char(8'h85);
        chk("eot_waits", eot, 1'b0);
        rd_status("status_eot_pend", 32'h0000_0304);
        ready = 1'b1;
        cyc = 0;
        while (!eot && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("eot_latency", cyc, 4);
        chk("eot_set", eot, 1'b1);
        chk("eot_code_lit", eot_code, 7'h05);
        wr_char(8'h41);
        @(posedge clk); #1;
        chk("dropped_char", char_valid, 1'b0);
        rd_status("status_eot", 32'h0000_000E);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tb_console_dev.md
# tb_console_dev

Memory-mapped console and end-of-test device for the CHERIoT simulation top. It sits downstream of the core's data port, alongside the data memory model, and decodes an 8-byte window at `BASE_ADDR`. Character writes are buffered in a show-ahead FIFO and drained over a valid/ready byte stream to the bench printer. A write with bit 7 set raises a sticky end-of-test indication once every buffered character has drained.

## Interface
- `BASE_ADDR`, default 32'h80040200: window base. Offset 0x0 is TXDATA; offset 0x4 is STATUS.
- `FIFO_DEPTH`, default 16: character FIFO entries. Must be a power of 2 and ≥ 2.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `data_req_i`  in  1  bus request
- `data_addr_i`  in  32  byte address
- `data_we_i`  in  1  write enable
- `data_be_i`  in  4  byte enables
- `data_wdata_i`  in  32  write data
- `data_gnt_o`  out  1  request accepted this cycle
- `data_rvalid_o`  out  1  response valid
- `data_rdata_o`  out  32  read data
- `data_err_o`  out  1  response error, qualified by rvalid
- `char_valid_o`  out  1  FIFO head valid
- `char_o`  out  8  FIFO head byte
- `char_ready_i`  in  1  printer consumes head when high with valid
- `eot_o`  out  1  end of test, sticky
- `eot_code_o`  out  7  wdata[6:0] of the end-of-test write

## Operation
- Hit: `data_req_i` and `data_addr_i[31:3] == BASE_ADDR[31:3]`. Misses are ignored: no gnt, no response.
- Gnt is combinational. It is high on every hit except a TXDATA write while the FIFO is full and `eot_pending` is 0. That case stalls the requester: gnt stays low until a slot frees.
- **TXDATA write**, `be[0]=1`:
  - wdata[7]=0 and eot not pending: push wdata[7:0] into the FIFO.
  - wdata[7]=1: set `eot_pending` and capture wdata[6:0] into `eot_code_o`. The byte is not pushed.
  - Any TXDATA write after `eot_pending` is set is granted and dropped.
- **TXDATA write with `be[0]=0`, or any write to STATUS:** granted, no side effect, error response.
- **STATUS read:** bit0 = full, bit1 = empty, bit2 = `eot_pending`, bit3 = `eot_o`, [15:8] = occupancy, all other bits 0.
- **TXDATA read:** returns 0, no error.
- FIFO pop occurs on `char_valid_o & char_ready_i`. `char_o` shows the head combinationally from storage (show-ahead).
- `eot_o` is registered. It sets on the cycle after `eot_pending` is 1 and the FIFO is empty, and stays set until reset.

## Timing
- Reset values: all outputs 0, FIFO empty, `eot_pending` 0, `eot_code_o` 0.
- Response: `data_rvalid_o` is high exactly one cycle after each gnt, with `rdata`/`err` valid in that cycle. Back-to-back grants give back-to-back rvalid.
- Push-to-output latency: a byte granted at edge N appears on `char_valid_o` after edge N (next cycle).
- Push and pop in the same cycle leave occupancy unchanged. A pop from full in cycle N allows gnt for a stalled write in cycle N+1, because full is evaluated from registered state.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- An EOT write while characters are buffered: `eot_o` waits until the last pop, rising the cycle after the FIFO becomes empty.
- Asynchronous reset mid-operation discards FIFO contents and any pending response. After reset, rvalid must not appear for the pre-reset gnt.

## Structure
- `tb_console_pkg` holds:
  - `TXDATA_OFS = 3'h0`, `STATUS_OFS = 3'h4`
  - STATUS bit-index constants
  - a packed `console_status_t` struct
- Sub-module `tb_console_fifo`: parameterised width/depth, show-ahead sync FIFO with push/pop/full/empty/count. The top holds the decode, response register and EOT logic.

## Test plan
- Reset, then write 0x48, 0x69 to 0x80040200 with `char_ready_i=1` -> gnt each cycle, rvalid at +1 with err=0, `char_o` 0x48 then 0x69, FIFO ends empty.
- Hold `char_ready_i=0` and write 17 bytes -> 16 granted, STATUS reads 0x1001 (full, count 16), 17th stalls. Raise ready for one pop -> 17th granted on the next cycle.
- With 3 bytes buffered and ready=0, write 0x85 -> `eot_pending`=1, `eot_o`=0. Raise ready -> 3 pops, `eot_o`=1 with code 0x05 the cycle after empty. A later write of 0x41 is dropped.
- Write to 0x80040204, and write TXDATA with be=4'b0010 -> rvalid with err=1, FIFO and STATUS unchanged.
- Accesses to 0x80040208 and 0x80040100 -> no gnt, no rvalid.
- Assert `rst_n` low the cycle after a grant with 5 bytes buffered -> no rvalid, all outputs 0, STATUS reads 0x2 after release.
